// File: rtl/pipeline_latch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_latch_ctrl
// Description : Applies the hazard unit's stall/flush controls to the four
//               pipeline boundary registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//               Owns the PC, the per-stage valid/instr/pc payload, a retire
//               pulse, saturating stall/flush/retire event counters and a
//               sticky protocol error flag for inconsistent stall patterns.
// Ports       :
//   CLK, RST                 clock (rising edge), async active-high reset
//   pc_en                    PC may advance (needs ihit as well)
//   stall_*/flush_*          per-boundary hold / bubble requests
//   pc_next                  next PC from fetch/branch logic
//   ihit, imem_instr         fetch complete strobe and fetched word
//   pc                       current PC
//   <stage>_valid/instr/pc   boundary register contents
//   retire                   registered pulse: instruction left MEM/WB
//   stall_cnt/flush_cnt/
//   retire_cnt               saturating event counters
//   protocol_err             sticky inconsistent-stall flag
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_latch_ctrl #(
    parameter int              PC_W     = 32,
    parameter int              IW       = 32,
    parameter logic [PC_W-1:0] PC_RESET = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             pc_en,
    input  logic             stall_ifid,
    input  logic             stall_idex,
    input  logic             stall_xmem,
    input  logic             stall_wb,
    input  logic             flush_ifid,
    input  logic             flush_idex,
    input  logic             flush_xmem,
    input  logic             flush_wb,
    input  logic [PC_W-1:0]  pc_next,
    input  logic             ihit,
    input  logic [IW-1:0]    imem_instr,
    output logic [PC_W-1:0]  pc,
    output logic             ifid_valid,
    output logic             idex_valid,
    output logic             exmem_valid,
    output logic             memwb_valid,
    output logic [IW-1:0]    ifid_instr,
    output logic [IW-1:0]    idex_instr,
    output logic [IW-1:0]    exmem_instr,
    output logic [IW-1:0]    memwb_instr,
    output logic [PC_W-1:0]  ifid_pc,
    output logic [PC_W-1:0]  idex_pc,
    output logic [PC_W-1:0]  exmem_pc,
    output logic [PC_W-1:0]  memwb_pc,
    output logic             retire,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             protocol_err
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic             ifid_valid_q, ifid_valid_d, idex_valid_q, idex_valid_d;
    logic             exmem_valid_q, exmem_valid_d, memwb_valid_q, memwb_valid_d;
    logic [IW-1:0]    ifid_instr_q, ifid_instr_d, idex_instr_q, idex_instr_d;
    logic [IW-1:0]    exmem_instr_q, exmem_instr_d, memwb_instr_q, memwb_instr_d;
    logic [PC_W-1:0]  ifid_pc_q, ifid_pc_d, idex_pc_q, idex_pc_d;
    logic [PC_W-1:0]  exmem_pc_q, exmem_pc_d, memwb_pc_q, memwb_pc_d;
    logic             retire_q, retire_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic             protocol_err_q, protocol_err_d;

    logic w_stall_any, w_flush_any, w_retire, w_lost_instr, w_fetch_while_held;

    always_comb begin
        pc_d = pc_q;
        if (pc_en && ihit) begin
            pc_d = pc_next;
        end

        // IF/ID: a fetch miss on advance inserts a bubble
        if (flush_ifid) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = '0;
            ifid_pc_d    = '0;
        end else if (stall_ifid) begin
            ifid_valid_d = ifid_valid_q;
            ifid_instr_d = ifid_instr_q;
            ifid_pc_d    = ifid_pc_q;
        end else begin
            ifid_valid_d = ihit;
            ifid_instr_d = ihit ? imem_instr : '0;
            ifid_pc_d    = ihit ? pc_q : '0;
        end

        // Invalid stages always carry zero payload, so a plain copy moves
        // bubbles downstream correctly.
        if (flush_idex) begin
            idex_valid_d = 1'b0;
            idex_instr_d = '0;
            idex_pc_d    = '0;
        end else if (stall_idex) begin
            idex_valid_d = idex_valid_q;
            idex_instr_d = idex_instr_q;
            idex_pc_d    = idex_pc_q;
        end else begin
            idex_valid_d = ifid_valid_q;
            idex_instr_d = ifid_instr_q;
            idex_pc_d    = ifid_pc_q;
        end

        if (flush_xmem) begin
            exmem_valid_d = 1'b0;
            exmem_instr_d = '0;
            exmem_pc_d    = '0;
        end else if (stall_xmem) begin
            exmem_valid_d = exmem_valid_q;
            exmem_instr_d = exmem_instr_q;
            exmem_pc_d    = exmem_pc_q;
        end else begin
            exmem_valid_d = idex_valid_q;
            exmem_instr_d = idex_instr_q;
            exmem_pc_d    = idex_pc_q;
        end

        if (flush_wb) begin
            memwb_valid_d = 1'b0;
            memwb_instr_d = '0;
            memwb_pc_d    = '0;
        end else if (stall_wb) begin
            memwb_valid_d = memwb_valid_q;
            memwb_instr_d = memwb_instr_q;
            memwb_pc_d    = memwb_pc_q;
        end else begin
            memwb_valid_d = exmem_valid_q;
            memwb_instr_d = exmem_instr_q;
            memwb_pc_d    = exmem_pc_q;
        end

        w_retire    = memwb_valid_q && !stall_wb && !flush_wb;
        retire_d    = w_retire;
        w_stall_any = stall_ifid | stall_idex | stall_xmem | stall_wb;
        w_flush_any = flush_ifid | flush_idex | flush_xmem | flush_wb;

        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (w_stall_any && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + C_CNT_ONE;
        end
        if (w_flush_any && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + C_CNT_ONE;
        end
        if (w_retire && (retire_cnt_q != '1)) begin
            retire_cnt_d = retire_cnt_q + C_CNT_ONE;
        end

        // Downstream held while upstream advances over a live instruction:
        // the upstream contents are overwritten and the instruction is lost.
        w_lost_instr = (stall_idex && !stall_ifid && !flush_ifid && ifid_valid_q)
                     | (stall_xmem && !stall_idex && !flush_idex && idex_valid_q)
                     | (stall_wb   && !stall_xmem && !flush_xmem && exmem_valid_q);
        // PC moves on while IF/ID holds: the fetched word is dropped.
        w_fetch_while_held = stall_ifid && pc_en && ihit;
        protocol_err_d = protocol_err_q | w_lost_instr | w_fetch_while_held;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q           <= PC_RESET;
            ifid_valid_q   <= 1'b0;
            idex_valid_q   <= 1'b0;
            exmem_valid_q  <= 1'b0;
            memwb_valid_q  <= 1'b0;
            ifid_instr_q   <= '0;
            idex_instr_q   <= '0;
            exmem_instr_q  <= '0;
            memwb_instr_q  <= '0;
            ifid_pc_q      <= '0;
            idex_pc_q      <= '0;
            exmem_pc_q     <= '0;
            memwb_pc_q     <= '0;
            retire_q       <= 1'b0;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
            retire_cnt_q   <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            ifid_valid_q   <= ifid_valid_d;
            idex_valid_q   <= idex_valid_d;
            exmem_valid_q  <= exmem_valid_d;
            memwb_valid_q  <= memwb_valid_d;
            ifid_instr_q   <= ifid_instr_d;
            idex_instr_q   <= idex_instr_d;
            exmem_instr_q  <= exmem_instr_d;
            memwb_instr_q  <= memwb_instr_d;
            ifid_pc_q      <= ifid_pc_d;
            idex_pc_q      <= idex_pc_d;
            exmem_pc_q     <= exmem_pc_d;
            memwb_pc_q     <= memwb_pc_d;
            retire_q       <= retire_d;
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            retire_cnt_q   <= retire_cnt_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign pc           = pc_q;
    assign ifid_valid   = ifid_valid_q;
    assign idex_valid   = idex_valid_q;
    assign exmem_valid  = exmem_valid_q;
    assign memwb_valid  = memwb_valid_q;
    assign ifid_instr   = ifid_instr_q;
    assign idex_instr   = idex_instr_q;
    assign exmem_instr  = exmem_instr_q;
    assign memwb_instr  = memwb_instr_q;
    assign ifid_pc      = ifid_pc_q;
    assign idex_pc      = idex_pc_q;
    assign exmem_pc     = exmem_pc_q;
    assign memwb_pc     = memwb_pc_q;
    assign retire       = retire_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
    assign retire_cnt   = retire_cnt_q;
    assign protocol_err = protocol_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_latch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_latch_ctrl
// Description : Directed, table-driven bench for pipeline_latch_ctrl
//               (CNT_W=4 so counter saturation is reachable).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_latch_ctrl;

    localparam int PC_W  = 32;
    localparam int IW    = 32;
    localparam int CNT_W = 4;

    localparam logic [31:0] I0 = 32'h8C01_0000, I1 = 32'h8C02_0004, I2 = 32'h8C03_0008;
    localparam logic [31:0] I3 = 32'h8C04_000C, I4 = 32'h8C05_0010, I5 = 32'h8C06_0014;
    localparam logic [31:0] I6 = 32'h8C07_0018, IB = 32'hAAAA_0040, IC = 32'hBBBB_0044;
    localparam logic [31:0] ID = 32'hCCCC_0048, IX = 32'hDEAD_BEEF;

    logic             CLK, RST;
    logic             pc_en, ihit;
    logic             stall_ifid, stall_idex, stall_xmem, stall_wb;
    logic             flush_ifid, flush_idex, flush_xmem, flush_wb;
    logic [PC_W-1:0]  pc_next, pc;
    logic [IW-1:0]    imem_instr;
    logic             ifid_valid, idex_valid, exmem_valid, memwb_valid;
    logic [IW-1:0]    ifid_instr, idex_instr, exmem_instr, memwb_instr;
    logic [PC_W-1:0]  ifid_pc, idex_pc, exmem_pc, memwb_pc;
    logic             retire, protocol_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, retire_cnt;

    int errors = 0;
    int checks = 0;

    pipeline_latch_ctrl #(
        .PC_W(PC_W), .IW(IW), .PC_RESET(32'h0), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RST(RST), .pc_en(pc_en),
        .stall_ifid(stall_ifid), .stall_idex(stall_idex),
        .stall_xmem(stall_xmem), .stall_wb(stall_wb),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .flush_xmem(flush_xmem), .flush_wb(flush_wb),
        .pc_next(pc_next), .ihit(ihit), .imem_instr(imem_instr),
        .pc(pc),
        .ifid_valid(ifid_valid), .idex_valid(idex_valid),
        .exmem_valid(exmem_valid), .memwb_valid(memwb_valid),
        .ifid_instr(ifid_instr), .idex_instr(idex_instr),
        .exmem_instr(exmem_instr), .memwb_instr(memwb_instr),
        .ifid_pc(ifid_pc), .idex_pc(idex_pc), .exmem_pc(exmem_pc), .memwb_pc(memwb_pc),
        .retire(retire), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .retire_cnt(retire_cnt), .protocol_err(protocol_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // stall/flush nibble order: {ifid, idex, xmem, wb}
    // valid nibble order:       {ifid, idex, exmem, memwb}
    typedef struct packed {
        logic        pc_en;
        logic        ihit;
        logic [3:0]  st;
        logic [3:0]  fl;
        logic [31:0] pc_next;
        logic [31:0] instr;
        logic [31:0] e_pc;
        logic [3:0]  e_v;
        logic [31:0] e_i_ifid;
        logic [31:0] e_i_idex;
        logic [31:0] e_i_exmem;
        logic [31:0] e_i_memwb;
        logic [31:0] e_ifid_pc;
        logic [31:0] e_memwb_pc;
        logic        e_ret;
        logic [3:0]  e_sc;
        logic [3:0]  e_fc;
        logic [3:0]  e_rc;
        logic        e_err;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic hit, input logic [3:0] st,
                         input logic [3:0] fl, input logic [31:0] nxt, input logic [31:0] ins);
        pc_en = en; ihit = hit;
        {stall_ifid, stall_idex, stall_xmem, stall_wb} = st;
        {flush_ifid, flush_idex, flush_xmem, flush_wb} = fl;
        pc_next = nxt; imem_instr = ins;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_valid"}, {28'h0, ifid_valid, idex_valid, exmem_valid, memwb_valid}, 32'h0);
        chk({tag, "_instr"}, ifid_instr | idex_instr | exmem_instr | memwb_instr, 32'h0);
        chk({tag, "_stagepc"}, ifid_pc | idex_pc | exmem_pc | memwb_pc, 32'h0);
        chk({tag, "_retire"}, {31'h0, retire}, 32'h0);
        chk({tag, "_cnts"}, {20'h0, stall_cnt, flush_cnt, retire_cnt}, 32'h0);
        chk({tag, "_err"}, {31'h0, protocol_err}, 32'h0);
    endtask

    initial begin
        //          en  hit st     fl     pc_next  instr | pc    valid  ifid idex exmem memwb ifidpc memwbpc ret sc fc rc err
        vecs[0]  = '{1'b1,1'b1,4'b0000,4'b0000,32'h04,I0, 32'h04,4'b1000,I0, 0, 0, 0, 32'h00,32'h00,1'b0,4'd0,4'd0,4'd0,1'b0};
        vecs[1]  = '{1'b1,1'b1,4'b0000,4'b0000,32'h08,I1, 32'h08,4'b1100,I1, I0,0, 0, 32'h04,32'h00,1'b0,4'd0,4'd0,4'd0,1'b0};
        vecs[2]  = '{1'b1,1'b1,4'b0000,4'b0000,32'h0C,I2, 32'h0C,4'b1110,I2, I1,I0,0, 32'h08,32'h00,1'b0,4'd0,4'd0,4'd0,1'b0};
        vecs[3]  = '{1'b1,1'b1,4'b0000,4'b0000,32'h10,I3, 32'h10,4'b1111,I3, I2,I1,I0,32'h0C,32'h00,1'b0,4'd0,4'd0,4'd0,1'b0};
        vecs[4]  = '{1'b1,1'b1,4'b0000,4'b0000,32'h14,I4, 32'h14,4'b1111,I4, I3,I2,I1,32'h10,32'h04,1'b1,4'd0,4'd0,4'd1,1'b0};
        // load-use stall: IF/ID and ID/EX hold, EX/MEM advances
        vecs[5]  = '{1'b0,1'b1,4'b1100,4'b0000,32'h18,I5, 32'h14,4'b1111,I4, I3,I3,I2,32'h10,32'h08,1'b1,4'd1,4'd0,4'd2,1'b0};
        vecs[6]  = '{1'b1,1'b1,4'b0000,4'b0000,32'h18,I5, 32'h18,4'b1111,I5, I4,I3,I3,32'h14,32'h0C,1'b1,4'd1,4'd0,4'd3,1'b0};
        // taken branch: flush IF/ID and ID/EX, redirect PC
        vecs[7]  = '{1'b1,1'b1,4'b0000,4'b1100,32'h40,I6, 32'h40,4'b0011,0, 0, I4,I3,32'h00,32'h0C,1'b1,4'd1,4'd1,4'd4,1'b0};
        vecs[8]  = '{1'b1,1'b1,4'b0000,4'b0000,32'h44,IB, 32'h44,4'b1001,IB, 0, 0, I4,32'h40,32'h10,1'b1,4'd1,4'd1,4'd5,1'b0};
        // fetch miss: bubble into IF/ID, PC holds
        vecs[9]  = '{1'b1,1'b0,4'b0000,4'b0000,32'h48,IX, 32'h44,4'b0100,0, IB,0, 0, 32'h00,32'h00,1'b1,4'd1,4'd1,4'd6,1'b0};
        vecs[10] = '{1'b1,1'b1,4'b0000,4'b0000,32'h48,IC, 32'h48,4'b1010,IC, 0, IB,0, 32'h44,32'h00,1'b0,4'd1,4'd1,4'd6,1'b0};
        // flush and stall on EX/MEM together: flush wins
        vecs[11] = '{1'b0,1'b0,4'b0010,4'b0010,32'h4C,IX, 32'h48,4'b0101,0, IC,0, IB,32'h00,32'h40,1'b0,4'd2,4'd2,4'd6,1'b0};
        vecs[12] = '{1'b0,1'b0,4'b0000,4'b0000,32'h4C,IX, 32'h48,4'b0010,0, 0, IC,0, 32'h00,32'h00,1'b1,4'd2,4'd2,4'd7,1'b0};
        vecs[13] = '{1'b1,1'b1,4'b0000,4'b0000,32'h4C,ID, 32'h4C,4'b1001,ID, 0, 0, IC,32'h48,32'h44,1'b0,4'd2,4'd2,4'd7,1'b0};
        // illegal: ID/EX stalled under a live, advancing IF/ID
        vecs[14] = '{1'b0,1'b0,4'b0100,4'b0000,32'h50,IX, 32'h4C,4'b0000,0, 0, 0, 0, 32'h00,32'h00,1'b1,4'd3,4'd2,4'd8,1'b1};
        vecs[15] = '{1'b0,1'b0,4'b0000,4'b0000,32'h50,IX, 32'h4C,4'b0000,0, 0, 0, 0, 32'h00,32'h00,1'b0,4'd3,4'd2,4'd8,1'b1};

        RST = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        chk_reset_state("reset");
        RST = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].pc_en, vecs[i].ihit, vecs[i].st, vecs[i].fl, vecs[i].pc_next, vecs[i].instr);
            @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d_valid", i),
                {28'h0, ifid_valid, idex_valid, exmem_valid, memwb_valid}, {28'h0, vecs[i].e_v});
            chk($sformatf("v%0d_ifid_instr", i), ifid_instr, vecs[i].e_i_ifid);
            chk($sformatf("v%0d_idex_instr", i), idex_instr, vecs[i].e_i_idex);
            chk($sformatf("v%0d_exmem_instr", i), exmem_instr, vecs[i].e_i_exmem);
            chk($sformatf("v%0d_memwb_instr", i), memwb_instr, vecs[i].e_i_memwb);
            chk($sformatf("v%0d_ifid_pc", i), ifid_pc, vecs[i].e_ifid_pc);
            chk($sformatf("v%0d_memwb_pc", i), memwb_pc, vecs[i].e_memwb_pc);
            chk($sformatf("v%0d_retire", i), {31'h0, retire}, {31'h0, vecs[i].e_ret});
            chk($sformatf("v%0d_stall_cnt", i), {28'h0, stall_cnt}, {28'h0, vecs[i].e_sc});
            chk($sformatf("v%0d_flush_cnt", i), {28'h0, flush_cnt}, {28'h0, vecs[i].e_fc});
            chk($sformatf("v%0d_retire_cnt", i), {28'h0, retire_cnt}, {28'h0, vecs[i].e_rc});
            chk($sformatf("v%0d_protocol_err", i), {31'h0, protocol_err}, {31'h0, vecs[i].e_err});
        end

        // Saturation: stall_cnt=3, flush_cnt=2 going in; stall_wb+flush_wb held 20 cycles
        drive(1'b0, 1'b0, 4'b0001, 4'b0001, 32'h0, 32'h0);
        for (int c = 1; c <= 20; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (c == 11) begin
                chk("sat_stall_c11", {28'h0, stall_cnt}, 32'd14);
                chk("sat_flush_c11", {28'h0, flush_cnt}, 32'd13);
            end
            if (c == 12) begin
                chk("sat_stall_c12", {28'h0, stall_cnt}, 32'd15);
            end
        end
        chk("sat_stall_c20", {28'h0, stall_cnt}, 32'd15);
        chk("sat_flush_c20", {28'h0, flush_cnt}, 32'd15);
        chk("sat_retire_cnt", {28'h0, retire_cnt}, 32'd8);
        chk("sat_err_sticky", {31'h0, protocol_err}, 32'd1);

        // Mid-stream asynchronous reset, asserted away from any clock edge
        drive(1'b1, 1'b1, 4'h0, 4'h0, 32'h200, 32'h1234_5678);
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        chk("pre_rst_ifid_valid", {31'h0, ifid_valid}, 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk_reset_state("async_rst");
        @(negedge CLK);
        chk_reset_state("rst_held");
        RST = 1'b0;

        // Fetch accepted while IF/ID is stalled: second error condition
        drive(1'b1, 1'b1, 4'b1000, 4'b0000, 32'h100, 32'h5555_0000);
        @(posedge CLK);
        @(negedge CLK);
        chk("fetch_held_err", {31'h0, protocol_err}, 32'd1);
        chk("fetch_held_pc", pc, 32'h100);
        chk("fetch_held_ifid_valid", {31'h0, ifid_valid}, 32'd0);
        chk("fetch_held_stall_cnt", {28'h0, stall_cnt}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
